// File: rtl/can_pkg.sv
// Shared definitions for the CAN 2.0A frame generator.
// Contents: frame-field state enum, field widths, bus level constants and the
// CRC-15 single-bit update function used by the frame FSM.
package can_pkg;

    localparam int unsigned ID_W  = 11;
    localparam int unsigned DLC_W = 4;
    localparam int unsigned CRC_W = 15;

    localparam logic [CRC_W-1:0] CRC15_POLY = 15'h4599;

    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;

    // Each non-idle state names the field whose next bit goes out on the coming bit_tick.
    // StWaitTick emits SOF; StAckDel is also where the ACK slot gets sampled.
    typedef enum logic [3:0] {
        StIdle,
        StWaitTick,
        StArb,
        StCtrl,
        StData,
        StCrc,
        StCrcDel,
        StAckSlot,
        StAckDel,
        StEof,
        StIfs
    } frame_state_e;

    function automatic logic [CRC_W-1:0] crc15_next(input logic [CRC_W-1:0] crc,
                                                     input logic             bit_in);
        logic             fb;
        logic [CRC_W-1:0] sh;
        fb = bit_in ^ crc[CRC_W-1];
        sh = {crc[CRC_W-2:0], 1'b0};
        return fb ? (sh ^ CRC15_POLY) : sh;
    endfunction

endpackage

// File: rtl/can_bit_stuffer.sv
// Run-length tracker for CAN bit stuffing.
// Ports:
//   clk, reset   - system clock, async active-high reset
//   clear_i      - restart run tracking (start of frame)
//   push_i       - a bit (frame or stuff) was just driven onto the bus
//   bit_i        - value of that bit
//   stall_o      - a stuff bit must be sent next; frame FSM holds its field position
//   stuff_bit_o  - value of the stuff bit to send
module can_bit_stuffer
    import can_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic push_i,
    input  logic bit_i,
    output logic stall_o,
    output logic stuff_bit_o
);

    localparam int unsigned      RUN_W   = $clog2(STUFF_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             last_q, last_d;

    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (clear_i) begin
            run_d  = '0;
            last_d = RECESSIVE;
        end else if (push_i) begin
            // A stuff bit is always the complement, so it naturally restarts the run at 1.
            if ((run_q != '0) && (bit_i == last_q)) begin
                run_d = run_q + RUN_ONE;
            end else begin
                run_d = RUN_ONE;
            end
            last_d = bit_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q  <= '0;
            last_q <= RECESSIVE;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

    assign stall_o     = (run_q == RUN_MAX);
    assign stuff_bit_o = ~last_q;

endmodule

// File: rtl/can_frame_gen.sv
// CAN 2.0A standard-frame serialiser.
// Snapshots the transmit buffer on an accepted tx_req and sends SOF, ID, RTR, control,
// data, CRC-15 (with bit stuffing), delimiters, ACK slot, EOF and intermission,
// one bit per bit_tick.
// Ports:
//   clk, reset               - system clock, async active-high reset
//   tx_buff_1..tx_buff_10    - ID[10:3]; {ID[2:0],RTR,DLC}; data bytes 0..7
//   tx_req                   - level request, only looked at in idle
//   bit_tick                 - one-clk bit boundary strobe
//   rx_bit                   - bus level, sampled at the end of the ACK slot
//   tx_bit                   - serial output, 1 = recessive
//   frame_gen_intl           - frame in flight, buffer must not reload
//   tx_done                  - pulse at end of intermission after a good ACK
//   ack_err                  - pulse when the ACK slot reads recessive
module can_frame_gen
    import can_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 5,
    parameter int unsigned EOF_BITS  = 7,
    parameter int unsigned IFS_BITS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_buff_1,
    input  logic [7:0] tx_buff_2,
    input  logic [7:0] tx_buff_3,
    input  logic [7:0] tx_buff_4,
    input  logic [7:0] tx_buff_5,
    input  logic [7:0] tx_buff_6,
    input  logic [7:0] tx_buff_7,
    input  logic [7:0] tx_buff_8,
    input  logic [7:0] tx_buff_9,
    input  logic [7:0] tx_buff_10,
    input  logic       tx_req,
    input  logic       bit_tick,
    input  logic       rx_bit,
    output logic       tx_bit,
    output logic       frame_gen_intl,
    output logic       tx_done,
    output logic       ack_err
);

    localparam logic [6:0] EOF_LAST = 7'(EOF_BITS - 1);
    localparam logic [6:0] IFS_END  = 7'(IFS_BITS);

    frame_state_e     state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rtr_q, rtr_d;
    logic [DLC_W-1:0] dlc_q, dlc_d;
    logic [63:0]      data_q, data_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             tx_bit_q, tx_bit_d;
    logic             intl_q, intl_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;

    logic             stf_clear, stf_push, stf_bit, stf_stall, stf_stuff_bit;

    logic [3:0]       n_bytes;
    logic [6:0]       data_bits;
    logic [11:0]      arb_vec;
    logic [5:0]       ctrl_vec;
    logic             field_bit;
    logic             field_last;
    frame_state_e     field_next;
    logic             stuff_zone, push_zone, crc_zone;

    can_bit_stuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_stuffer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (stf_clear),
        .push_i      (stf_push),
        .bit_i       (stf_bit),
        .stall_o     (stf_stall),
        .stuff_bit_o (stf_stuff_bit)
    );

    // DLC 9..15 still only carries 8 bytes; remote frames carry none.
    assign n_bytes   = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);
    assign data_bits = {n_bytes, 3'b000};

    assign stuff_zone = state_q inside {StWaitTick, StArb, StCtrl, StData, StCrc, StCrcDel};
    assign push_zone  = state_q inside {StWaitTick, StArb, StCtrl, StData, StCrc};
    assign crc_zone   = state_q inside {StWaitTick, StArb, StCtrl, StData};

    // Bit to send for the current field position, and where the field goes next.
    always_comb begin
        arb_vec    = {id_q, rtr_q};
        ctrl_vec   = {DOMINANT, DOMINANT, dlc_q};
        field_bit  = RECESSIVE;
        field_last = 1'b1;
        field_next = StIdle;
        case (state_q)
            StWaitTick: begin
                field_bit  = DOMINANT;
                field_next = StArb;
            end
            StArb: begin
                field_bit  = arb_vec[4'd11 - cnt_q[3:0]];
                field_last = (cnt_q == 7'd11);
                field_next = StCtrl;
            end
            StCtrl: begin
                field_bit  = ctrl_vec[3'd5 - cnt_q[2:0]];
                field_last = (cnt_q == 7'd5);
                field_next = (data_bits == 7'd0) ? StCrc : StData;
            end
            StData: begin
                field_bit  = data_q[6'd63 - cnt_q[5:0]];
                field_last = (cnt_q == data_bits - 7'd1);
                field_next = StCrc;
            end
            StCrc: begin
                field_bit  = crc_q[4'd14 - cnt_q[3:0]];
                field_last = (cnt_q == 7'd14);
                field_next = StCrcDel;
            end
            StCrcDel:  field_next = StAckSlot;
            StAckSlot: field_next = StAckDel;
            StAckDel:  field_next = StEof;
            StEof: begin
                field_last = (cnt_q == EOF_LAST);
                field_next = StIfs;
            end
            default:   field_next = StIdle;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        rtr_d     = rtr_q;
        dlc_d     = dlc_q;
        data_d    = data_q;
        crc_d     = crc_q;
        tx_bit_d  = tx_bit_q;
        intl_d    = intl_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        stf_clear = 1'b0;
        stf_push  = 1'b0;
        stf_bit   = field_bit;

        if (state_q == StIdle) begin
            if (tx_req) begin
                id_d      = {tx_buff_1, tx_buff_2[7:5]};
                rtr_d     = tx_buff_2[4];
                dlc_d     = tx_buff_2[3:0];
                data_d    = {tx_buff_3, tx_buff_4, tx_buff_5, tx_buff_6,
                             tx_buff_7, tx_buff_8, tx_buff_9, tx_buff_10};
                crc_d     = '0;
                cnt_d     = '0;
                intl_d    = 1'b1;
                stf_clear = 1'b1;
                state_d   = StWaitTick;
            end
        end else if (bit_tick) begin
            if (stuff_zone && stf_stall) begin
                // Stuff bit: field position and CRC stand still.
                tx_bit_d = stf_stuff_bit;
                stf_push = 1'b1;
                stf_bit  = stf_stuff_bit;
            end else begin
                case (state_q)
                    StAckDel: begin
                        if (rx_bit == RECESSIVE) begin
                            ack_err_d = 1'b1;
                            tx_bit_d  = RECESSIVE;
                            intl_d    = 1'b0;
                            state_d   = StIdle;
                        end else begin
                            tx_bit_d = RECESSIVE;
                            cnt_d    = '0;
                            state_d  = field_next;
                        end
                    end
                    StIfs: begin
                        if (cnt_q == IFS_END) begin
                            done_d  = 1'b1;
                            intl_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            tx_bit_d = RECESSIVE;
                            cnt_d    = cnt_q + 7'd1;
                        end
                    end
                    default: begin
                        tx_bit_d = field_bit;
                        cnt_d    = cnt_q + 7'd1;
                        if (crc_zone) begin
                            crc_d = crc15_next(crc_q, field_bit);
                        end
                        if (push_zone) begin
                            stf_push = 1'b1;
                        end
                        if (field_last) begin
                            cnt_d   = '0;
                            state_d = field_next;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            id_q      <= '0;
            rtr_q     <= 1'b0;
            dlc_q     <= '0;
            data_q    <= '0;
            crc_q     <= '0;
            tx_bit_q  <= RECESSIVE;
            intl_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            rtr_q     <= rtr_d;
            dlc_q     <= dlc_d;
            data_q    <= data_d;
            crc_q     <= crc_d;
            tx_bit_q  <= tx_bit_d;
            intl_q    <= intl_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign tx_bit         = tx_bit_q;
    assign frame_gen_intl = intl_q;
    assign tx_done        = done_q;
    assign ack_err        = ack_err_q;

endmodule

// File: tb/tb_can_frame_gen.sv
// Self-checking bench for can_frame_gen: a frame-level reference model builds the
// expected bit sequence for each accepted request and one process compares every cycle.
module tb_can_frame_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tb_buf [10];
    logic       tx_req, bit_tick, rx_bit;
    logic       tx_bit, frame_gen_intl, tx_done, ack_err;

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int n_err  = 0;

    // Reference model state
    bit         m_unst[$];
    bit         m_seq[$];
    int         m_ack_idx;
    int         m_stuff_cnt;
    logic [14:0] m_crc;
    int         m_tick;
    bit         m_active;
    logic       m_tx, m_done, m_err;

    can_frame_gen dut (
        .clk            (clk),
        .reset          (reset),
        .tx_buff_1      (tb_buf[0]),
        .tx_buff_2      (tb_buf[1]),
        .tx_buff_3      (tb_buf[2]),
        .tx_buff_4      (tb_buf[3]),
        .tx_buff_5      (tb_buf[4]),
        .tx_buff_6      (tb_buf[5]),
        .tx_buff_7      (tb_buf[6]),
        .tx_buff_8      (tb_buf[7]),
        .tx_buff_9      (tb_buf[8]),
        .tx_buff_10     (tb_buf[9]),
        .tx_req         (tx_req),
        .bit_tick       (bit_tick),
        .rx_bit         (rx_bit),
        .tx_bit         (tx_bit),
        .frame_gen_intl (frame_gen_intl),
        .tx_done        (tx_done),
        .ack_err        (ack_err)
    );

    initial forever #5 clk = ~clk;

    // bit_tick: one clk in four
    initial begin
        int div;
        div = 0;
        bit_tick = 1'b0;
        forever begin
            @(negedge clk);
            div = div + 1;
            bit_tick = (div % 4 == 0);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Build the full on-wire bit sequence for the frame held in tb_buf.
    task automatic build_frame();
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        int          n;
        logic [14:0] crc;
        logic        fb;
        bit          stream[$];
        bit          last;
        int          run;
        id  = {tb_buf[0], tb_buf[1][7:5]};
        rtr = tb_buf[1][4];
        dlc = tb_buf[1][3:0];
        n   = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        m_unst.delete();
        m_unst.push_back(1'b0);
        for (int i = 10; i >= 0; i--) m_unst.push_back(id[i]);
        m_unst.push_back(rtr);
        m_unst.push_back(1'b0);
        m_unst.push_back(1'b0);
        for (int i = 3; i >= 0; i--) m_unst.push_back(dlc[i]);
        for (int k = 0; k < n; k++)
            for (int i = 7; i >= 0; i--) m_unst.push_back(tb_buf[2 + k][i]);
        crc = '0;
        foreach (m_unst[j]) begin
            fb  = m_unst[j] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        m_crc  = crc;
        stream = m_unst;
        for (int i = 14; i >= 0; i--) stream.push_back(crc[i]);
        m_seq.delete();
        m_stuff_cnt = 0;
        run  = 0;
        last = 1'b0;
        foreach (stream[j]) begin
            m_seq.push_back(stream[j]);
            if (run > 0 && stream[j] == last) run++;
            else run = 1;
            last = stream[j];
            if (run == 5) begin
                m_seq.push_back(~last);
                last = ~last;
                run  = 1;
                m_stuff_cnt++;
            end
        end
        m_seq.push_back(1'b1);                 // CRC delimiter
        m_seq.push_back(1'b1);                 // ACK slot
        m_ack_idx = m_seq.size() - 1;
        m_seq.push_back(1'b1);                 // ACK delimiter
        for (int i = 0; i < 7; i++) m_seq.push_back(1'b1);
        for (int i = 0; i < 3; i++) m_seq.push_back(1'b1);
    endtask

    // Model update at each rising edge, DUT comparison 1 ns later.
    initial begin
        m_active = 0;
        m_tx     = 1'b1;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_tick   = 0;
        forever begin
            @(posedge clk);
            m_done = 1'b0;
            m_err  = 1'b0;
            if (reset) begin
                m_active = 0;
                m_tx     = 1'b1;
            end else if (!m_active) begin
                if (tx_req) begin
                    build_frame();
                    m_active = 1;
                    m_tick   = 0;
                end
            end else if (bit_tick) begin
                if (m_tick == m_ack_idx + 1 && rx_bit) begin
                    m_err    = 1'b1;
                    m_tx     = 1'b1;
                    m_active = 0;
                end else if (m_tick == m_seq.size()) begin
                    m_done   = 1'b1;
                    m_active = 0;
                end else begin
                    m_tx = m_seq[m_tick];
                    m_tick++;
                end
            end
            #1;
            check("tx_bit", tx_bit, m_tx);
            check("frame_gen_intl", frame_gen_intl, m_active);
            check("tx_done", tx_done, m_done);
            check("ack_err", ack_err, m_err);
            if (tx_done) n_done++;
            if (ack_err) n_err++;
        end
    end

    task automatic load(input logic [7:0] b1, input logic [7:0] b2, input logic [63:0] d);
        tb_buf[0] = b1;
        tb_buf[1] = b2;
        for (int i = 0; i < 8; i++) tb_buf[2 + i] = d[63 - 8*i -: 8];
    endtask

    // Request one frame, then corrupt the buffer to prove the snapshot is used.
    task automatic start_frame(input logic ack_level);
        @(negedge clk);
        rx_bit = ack_level;
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        for (int i = 0; i < 10; i++) tb_buf[i] = ~tb_buf[i];
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((m_active || frame_gen_intl) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (m_active || frame_gen_intl) begin
            errors++;
            $display("FAIL %s timeout: intl=%b after %0d cycles, expected 0", name,
                     frame_gen_intl, cyc);
        end
    endtask

    initial begin
        int       d0, e0, cyc;
        logic [11:0] v12;
        logic [6:0]  v7;
        logic [3:0]  v4;
        reset  = 1'b1;
        tx_req = 1'b0;
        rx_bit = 1'b0;
        for (int i = 0; i < 10; i++) tb_buf[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset tx_bit", tx_bit, 1'b1);
        check("reset intl", frame_gen_intl, 1'b0);
        check("reset tx_done", tx_done, 1'b0);
        check("reset ack_err", ack_err, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ID 0x123, DLC 1, data 0xAA
        d0 = n_done; e0 = n_err;
        load(8'h24, 8'h61, 64'hAA00_0000_0000_0000);
        start_frame(1'b0);
        check_int("t1 unstuffed length", m_unst.size(), 27);
        for (int i = 0; i < 12; i++) v12[11 - i] = m_unst[i];
        check_int("t1 sof+id bits", int'(v12), 12'h123);
        wait_idle("t1");
        check_int("t1 done pulses", n_done - d0, 1);
        check_int("t1 err pulses", n_err - e0, 0);

        // ID 0, DLC 0: all-zero payload, heavy stuffing
        d0 = n_done;
        load(8'h00, 8'h00, 64'h0);
        start_frame(1'b0);
        check_int("t2 crc", int'(m_crc), 0);
        check_int("t2 stuff count", m_stuff_cnt, 6);
        for (int i = 0; i < 7; i++) v7[6 - i] = m_seq[i];
        check_int("t2 first bits", int'(v7), 7'b0000010);
        wait_idle("t2");
        check_int("t2 done pulses", n_done - d0, 1);

        // RTR=1, DLC=8: no data field
        d0 = n_done;
        load(8'hB4, 8'h78, 64'hFFFF_FFFF_FFFF_FFFF);
        start_frame(1'b0);
        check_int("t3 unstuffed length", m_unst.size(), 19);
        for (int i = 0; i < 4; i++) v4[3 - i] = m_unst[15 + i];
        check_int("t3 dlc bits", int'(v4), 4'b1000);
        wait_idle("t3");
        check_int("t3 done pulses", n_done - d0, 1);

        // DLC=12: 8 bytes sent, raw DLC transmitted
        d0 = n_done;
        load(8'h3C, 8'hAC, 64'h0123_4567_89AB_CDEF);
        start_frame(1'b0);
        check_int("t4 unstuffed length", m_unst.size(), 83);
        for (int i = 0; i < 4; i++) v4[3 - i] = m_unst[15 + i];
        check_int("t4 dlc bits", int'(v4), 4'b1100);
        wait_idle("t4");
        check_int("t4 done pulses", n_done - d0, 1);

        // Recessive ACK slot with tx_req held: error, then immediate restart
        d0 = n_done; e0 = n_err;
        load(8'h81, 8'h42, 64'h5A00_0000_0000_0000);
        @(negedge clk);
        rx_bit = 1'b1;
        tx_req = 1'b1;
        @(negedge clk);
        wait_idle("t5 nack");
        check_int("t5 err pulses", n_err - e0, 1);
        check_int("t5 no done", n_done - d0, 0);
        rx_bit = 1'b0;
        @(negedge clk);
        tx_req = 1'b0;
        check("t5 restart intl", frame_gen_intl, 1'b1);
        wait_idle("t5 retry");
        check_int("t5 retry done", n_done - d0, 1);
        check_int("t5 retry err", n_err - e0, 1);

        // Reset in the middle of the data field
        load(8'h55, 8'h48, 64'h0);
        start_frame(1'b0);
        repeat (160) @(negedge clk);
        cyc = 0;
        while (tx_bit !== 1'b0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        #1;
        check("t6 async tx_bit", tx_bit, 1'b1);
        check("t6 async intl", frame_gen_intl, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Clean frame after reset
        d0 = n_done;
        load(8'h24, 8'h61, 64'h5500_0000_0000_0000);
        start_frame(1'b0);
        wait_idle("t7");
        check_int("t7 done pulses", n_done - d0, 1);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
